// File: rtl/execute_stage.sv
// Execute stage of the RV32I pipeline: ID/EX register, ALU, branch/jump target and taken decision.
// Define FORWARDING_EN to add the rs1/rs2 forwarding muxes and their ports.
module execute_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_e,
    input  logic                     reg_write_d,
    input  logic                     mem_write_d,
    input  logic                     jump_d,
    input  logic                     branch_d,
    input  logic [1:0]               res_src_d,
    input  logic [3:0]               alu_control_d,
    input  logic [2:0]               funct3_d,
    input  logic                     alu_src_a_d,
    input  logic                     alu_src_b_d,
    input  logic                     adder_src_d,
    input  logic [DATA_WIDTH-1:0]    rd1_d,
    input  logic [DATA_WIDTH-1:0]    rd2_d,
    input  logic [ADDRESS_WIDTH-1:0] pc_d,
    input  logic [ADDRESS_WIDTH-1:0] pc_plus4_d,
    input  logic [4:0]               rs1_d,
    input  logic [4:0]               rs2_d,
    input  logic [4:0]               rd_d,
    input  logic [DATA_WIDTH-1:0]    imm_val_d,
`ifdef FORWARDING_EN
    input  logic [1:0]               forward_a_e,
    input  logic [1:0]               forward_b_e,
    input  logic [DATA_WIDTH-1:0]    alu_result_m,
    input  logic [DATA_WIDTH-1:0]    result_w,
`endif
    output logic                     reg_write_e,
    output logic                     mem_write_e,
    output logic [1:0]               res_src_e,
    output logic [2:0]               funct3_e,
    output logic [4:0]               rd_e,
    output logic [4:0]               rs1_e,
    output logic [4:0]               rs2_e,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_e,
    output logic [DATA_WIDTH-1:0]    alu_result_e,
    output logic [DATA_WIDTH-1:0]    write_data_e,
    output logic [ADDRESS_WIDTH-1:0] pc_target_e,
    output logic                     pc_src_e
);

    logic                     reg_write_p0, mem_write_p0, jump_p0, branch_p0;
    logic [1:0]               res_src_p0;
    logic [3:0]               alu_control_p0;
    logic [2:0]               funct3_p0;
    logic                     alu_src_a_p0, alu_src_b_p0, adder_src_p0;
    logic [DATA_WIDTH-1:0]    rd1_p0, rd2_p0, imm_p0;
    logic [ADDRESS_WIDTH-1:0] pc_p0, pc_plus4_p0;
    logic [4:0]               rs1_p0, rs2_p0, rd_p0;

    logic [DATA_WIDTH-1:0]    src_a_val, src_b_val, op_a, op_b, jalr_sum;

    function automatic logic [DATA_WIDTH-1:0] alu_op(input logic [3:0] op,
                                                     input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
        logic signed [DATA_WIDTH-1:0] sa;
        logic signed [DATA_WIDTH-1:0] sb;
        logic [4:0] shamt;
        sa    = $signed(a);
        sb    = $signed(b);
        shamt = b[4:0];
        case (op)
            4'b0000: alu_op = a + b;
            4'b0001: alu_op = a - b;
            4'b0010: alu_op = a & b;
            4'b0011: alu_op = a | b;
            4'b0100: alu_op = a ^ b;
            4'b0101: alu_op = {{(DATA_WIDTH-1){1'b0}}, (sa < sb)};
            4'b0110: alu_op = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
            4'b0111: alu_op = a << shamt;
            4'b1000: alu_op = a >> shamt;
            4'b1001: alu_op = $unsigned(sa >>> shamt);
            4'b1010: alu_op = b;
            default: alu_op = '0;
        endcase
    endfunction

    function automatic logic branch_cond(input logic [2:0] f3,
                                         input logic [DATA_WIDTH-1:0] a,
                                         input logic [DATA_WIDTH-1:0] b);
        logic signed [DATA_WIDTH-1:0] sa;
        logic signed [DATA_WIDTH-1:0] sb;
        sa = $signed(a);
        sb = $signed(b);
        case (f3)
            3'b000:  branch_cond = (a == b);
            3'b001:  branch_cond = (a != b);
            3'b100:  branch_cond = (sa < sb);
            3'b101:  branch_cond = (sa >= sb);
            3'b110:  branch_cond = (a < b);
            3'b111:  branch_cond = (a >= b);
            default: branch_cond = 1'b0;
        endcase
    endfunction

`ifdef FORWARDING_EN
    function automatic logic [DATA_WIDTH-1:0] fwd_sel(input logic [1:0] sel,
                                                      input logic [DATA_WIDTH-1:0] reg_val,
                                                      input logic [DATA_WIDTH-1:0] mem_val,
                                                      input logic [DATA_WIDTH-1:0] wb_val);
        case (sel)
            2'b01:   fwd_sel = wb_val;
            2'b10:   fwd_sel = mem_val;
            default: fwd_sel = reg_val;
        endcase
    endfunction
`endif

    // Stage p0: ID/EX register; flush loads a NOP bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush_e) begin
            reg_write_p0   <= 1'b0;
            mem_write_p0   <= 1'b0;
            jump_p0        <= 1'b0;
            branch_p0      <= 1'b0;
            res_src_p0     <= '0;
            alu_control_p0 <= '0;
            funct3_p0      <= '0;
            alu_src_a_p0   <= 1'b0;
            alu_src_b_p0   <= 1'b0;
            adder_src_p0   <= 1'b0;
            rd1_p0         <= '0;
            rd2_p0         <= '0;
            imm_p0         <= '0;
            pc_p0          <= '0;
            pc_plus4_p0    <= '0;
            rs1_p0         <= '0;
            rs2_p0         <= '0;
            rd_p0          <= '0;
        end else begin
            reg_write_p0   <= reg_write_d;
            mem_write_p0   <= mem_write_d;
            jump_p0        <= jump_d;
            branch_p0      <= branch_d;
            res_src_p0     <= res_src_d;
            alu_control_p0 <= alu_control_d;
            funct3_p0      <= funct3_d;
            alu_src_a_p0   <= alu_src_a_d;
            alu_src_b_p0   <= alu_src_b_d;
            adder_src_p0   <= adder_src_d;
            rd1_p0         <= rd1_d;
            rd2_p0         <= rd2_d;
            imm_p0         <= imm_val_d;
            pc_p0          <= pc_d;
            pc_plus4_p0    <= pc_plus4_d;
            rs1_p0         <= rs1_d;
            rs2_p0         <= rs2_d;
            rd_p0          <= rd_d;
        end
    end

    // Stage p1 (combinational): operand select, ALU, target adder, branch decision
    always_comb begin
`ifdef FORWARDING_EN
        src_a_val = fwd_sel(forward_a_e, rd1_p0, alu_result_m, result_w);
        src_b_val = fwd_sel(forward_b_e, rd2_p0, alu_result_m, result_w);
`else
        src_a_val = rd1_p0;
        src_b_val = rd2_p0;
`endif
        op_a     = alu_src_a_p0 ? DATA_WIDTH'(pc_p0) : src_a_val;
        op_b     = alu_src_b_p0 ? imm_p0 : src_b_val;
        jalr_sum = src_a_val + imm_p0;
        if (adder_src_p0)
            pc_target_e = ADDRESS_WIDTH'({jalr_sum[DATA_WIDTH-1:1], 1'b0});
        else
            pc_target_e = pc_p0 + ADDRESS_WIDTH'(imm_p0);
        alu_result_e = alu_op(alu_control_p0, op_a, op_b);
        pc_src_e     = jump_p0 | (branch_p0 & branch_cond(funct3_p0, src_a_val, src_b_val));
    end

    assign write_data_e = src_b_val;
    assign reg_write_e  = reg_write_p0;
    assign mem_write_e  = mem_write_p0;
    assign res_src_e    = res_src_p0;
    assign funct3_e     = funct3_p0;
    assign rd_e         = rd_p0;
    assign rs1_e        = rs1_p0;
    assign rs2_e        = rs2_p0;
    assign pc_plus4_e   = pc_plus4_p0;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed vector table, reset/flush sequence, random vs. reference model.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_e;
    logic        reg_write_d, mem_write_d, jump_d, branch_d;
    logic [1:0]  res_src_d;
    logic [3:0]  alu_control_d;
    logic [2:0]  funct3_d;
    logic        alu_src_a_d, alu_src_b_d, adder_src_d;
    logic [31:0] rd1_d, rd2_d, pc_d, pc_plus4_d, imm_val_d;
    logic [4:0]  rs1_d, rs2_d, rd_d;
    logic        reg_write_e, mem_write_e;
    logic [1:0]  res_src_e;
    logic [2:0]  funct3_e;
    logic [4:0]  rd_e, rs1_e, rs2_e;
    logic [31:0] pc_plus4_e, alu_result_e, write_data_e, pc_target_e;
    logic        pc_src_e;
`ifdef FORWARDING_EN
    logic [1:0]  forward_a_e, forward_b_e;
    logic [31:0] alu_result_m, result_w;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    execute_stage dut (
        .clk(clk), .rst(rst), .flush_e(flush_e),
        .reg_write_d(reg_write_d), .mem_write_d(mem_write_d), .jump_d(jump_d), .branch_d(branch_d),
        .res_src_d(res_src_d), .alu_control_d(alu_control_d), .funct3_d(funct3_d),
        .alu_src_a_d(alu_src_a_d), .alu_src_b_d(alu_src_b_d), .adder_src_d(adder_src_d),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .imm_val_d(imm_val_d),
`ifdef FORWARDING_EN
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .alu_result_m(alu_result_m), .result_w(result_w),
`endif
        .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .res_src_e(res_src_e),
        .funct3_e(funct3_e), .rd_e(rd_e), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .pc_plus4_e(pc_plus4_e), .alu_result_e(alu_result_e), .write_data_e(write_data_e),
        .pc_target_e(pc_target_e), .pc_src_e(pc_src_e)
    );

    typedef struct {
        logic [3:0]  alu;
        logic [2:0]  f3;
        logic        branch, jump, src_a, src_b, adder;
        logic [31:0] rd1, rd2, pc, imm;
        logic [31:0] exp_alu, exp_wd, exp_tgt;
        logic        exp_src;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".reg_write"}, 32'(reg_write_e), 0);
        chk({tag, ".mem_write"}, 32'(mem_write_e), 0);
        chk({tag, ".res_src"}, 32'(res_src_e), 0);
        chk({tag, ".funct3"}, 32'(funct3_e), 0);
        chk({tag, ".rd"}, 32'(rd_e), 0);
        chk({tag, ".rs1"}, 32'(rs1_e), 0);
        chk({tag, ".rs2"}, 32'(rs2_e), 0);
        chk({tag, ".pc_plus4"}, pc_plus4_e, 0);
        chk({tag, ".alu"}, alu_result_e, 0);
        chk({tag, ".wdata"}, write_data_e, 0);
        chk({tag, ".target"}, pc_target_e, 0);
        chk({tag, ".pc_src"}, 32'(pc_src_e), 0);
    endtask

    function automatic vec_t mk(input logic [3:0] alu, input logic [2:0] f3,
                                input logic branch, input logic jump, input logic src_a,
                                input logic src_b, input logic adder,
                                input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic [31:0] pc, input logic [31:0] imm,
                                input logic [31:0] e_alu, input logic [31:0] e_wd,
                                input logic [31:0] e_tgt, input logic e_src);
        vec_t v;
        v.alu = alu; v.f3 = f3; v.branch = branch; v.jump = jump;
        v.src_a = src_a; v.src_b = src_b; v.adder = adder;
        v.rd1 = rd1; v.rd2 = rd2; v.pc = pc; v.imm = imm;
        v.exp_alu = e_alu; v.exp_wd = e_wd; v.exp_tgt = e_tgt; v.exp_src = e_src;
        return v;
    endfunction

    // Reference model: behaviour taken straight from the instruction-set rules
    function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned s;
        longint sa, sb;
        s  = b % 32;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            0:  return a + b;
            1:  return a + (~b + 1);
            2:  return a & b;
            3:  return a | b;
            4:  return a ^ b;
            5:  return (sa < sb) ? 1 : 0;
            6:  return (longint'(a) < longint'(b)) ? 1 : 0;
            7:  return 32'(longint'(a) * (longint'(1) << s));
            8:  return 32'(longint'(a) / (longint'(1) << s));
            9:  return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
            10: return b;
            default: return 0;
        endcase
    endfunction

    function automatic logic model_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        ua = longint'(a);          ub = longint'(b);
        case (f3)
            0: return ua == ub;
            1: return ua != ub;
            4: return sa < sb;
            5: return !(sa < sb);
            6: return ua < ub;
            7: return !(ua < ub);
            default: return 0;
        endcase
    endfunction

    task automatic drive(input vec_t v);
        alu_control_d = v.alu; funct3_d = v.f3; branch_d = v.branch; jump_d = v.jump;
        alu_src_a_d = v.src_a; alu_src_b_d = v.src_b; adder_src_d = v.adder;
        rd1_d = v.rd1; rd2_d = v.rd2; pc_d = v.pc; imm_val_d = v.imm;
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        chk({tag, ".alu"}, alu_result_e, v.exp_alu);
        chk({tag, ".wdata"}, write_data_e, v.exp_wd);
        chk({tag, ".target"}, pc_target_e, v.exp_tgt);
        chk({tag, ".pc_src"}, 32'(pc_src_e), 32'(v.exp_src));
    endtask

    initial begin
        vec_t v;
        logic [31:0] a_val, b_val, tgt;
        logic [4:0]  rd_exp;
        logic [31:0] pcp4_exp;

        vecs[0]  = mk(4'b0000, 3'b000, 0, 0, 0, 0, 0, 32'h10, 32'h20, 32'h0, 32'h0, 32'h30, 32'h20, 32'h0, 0);
        vecs[1]  = mk(4'b0001, 3'b000, 0, 0, 0, 0, 0, 32'h10, 32'h20, 32'h0, 32'h0, 32'hFFFF_FFF0, 32'h20, 32'h0, 0);
        vecs[2]  = mk(4'b0000, 3'b000, 1, 0, 0, 0, 0, 32'h5, 32'h5, 32'h100, 32'h8, 32'hA, 32'h5, 32'h108, 1);
        vecs[3]  = mk(4'b0000, 3'b000, 1, 0, 0, 0, 0, 32'h5, 32'h6, 32'h100, 32'h8, 32'hB, 32'h6, 32'h108, 0);
        vecs[4]  = mk(4'b0000, 3'b100, 1, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h8, 32'h0, 32'h1, 32'h108, 1);
        vecs[5]  = mk(4'b0000, 3'b000, 0, 1, 0, 0, 1, 32'h1001, 32'h0, 32'h0, 32'h4, 32'h1001, 32'h0, 32'h1004, 1);
        vecs[6]  = mk(4'b1001, 3'b000, 0, 0, 0, 1, 0, 32'h8000_0000, 32'h0, 32'h0, 32'h4, 32'hF800_0000, 32'h0, 32'h4, 0);
        vecs[7]  = mk(4'b0110, 3'b000, 0, 0, 0, 0, 0, 32'h1, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h1, 32'hFFFF_FFFF, 32'h0, 0);
        vecs[8]  = mk(4'b0101, 3'b000, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 32'h1, 32'h1, 32'h0, 0);
        vecs[9]  = mk(4'b1010, 3'b000, 0, 0, 0, 1, 0, 32'h7, 32'h9, 32'h0, 32'h1234_5000, 32'h1234_5000, 32'h9, 32'h1234_5000, 0);
        vecs[10] = mk(4'b0000, 3'b000, 0, 0, 1, 1, 0, 32'h55, 32'h66, 32'h200, 32'h10, 32'h210, 32'h66, 32'h210, 0);
        vecs[11] = mk(4'b1111, 3'b000, 0, 0, 0, 0, 0, 32'h5, 32'h6, 32'h0, 32'h0, 32'h0, 32'h6, 32'h0, 0);
        vecs[12] = mk(4'b0000, 3'b111, 1, 0, 0, 0, 0, 32'h1, 32'hFFFF_FFFF, 32'h40, 32'hFFFF_FFF8, 32'h0, 32'hFFFF_FFFF, 32'h38, 0);
        vecs[13] = mk(4'b0111, 3'b010, 1, 0, 0, 1, 0, 32'h3, 32'h3, 32'h0, 32'h21, 32'h6, 32'h3, 32'h21, 0);

        rst = 1'b1; flush_e = 1'b0;
        reg_write_d = 0; mem_write_d = 0; jump_d = 0; branch_d = 0; res_src_d = 0;
        alu_control_d = 0; funct3_d = 0; alu_src_a_d = 0; alu_src_b_d = 0; adder_src_d = 0;
        rd1_d = 0; rd2_d = 0; pc_d = 0; pc_plus4_d = 0; imm_val_d = 0;
        rs1_d = 0; rs2_d = 0; rd_d = 0;
`ifdef FORWARDING_EN
        forward_a_e = 2'b00; forward_b_e = 2'b00; alu_result_m = 0; result_w = 0;
`endif
        @(posedge clk); #1;
        chk_all_zero("reset");
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i]);
            @(posedge clk); #1;
            check_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Async reset mid-cycle, then a flush bubble
        mem_write_d = 1; reg_write_d = 1; rd_d = 5'd2; res_src_d = 2'b01; pc_plus4_d = 32'h44;
        drive(vecs[2]);
        @(posedge clk); #1;
        chk("load.reg_write", 32'(reg_write_e), 1);
        chk("load.mem_write", 32'(mem_write_e), 1);
        chk("load.rd", 32'(rd_e), 2);
        chk("load.pc_src", 32'(pc_src_e), 1);
        #2 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        #1 rst = 1'b0;
        flush_e = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("flush");
        flush_e = 1'b0;
        @(posedge clk); #1;
        chk("reload.rd", 32'(rd_e), 2);
        chk("reload.target", pc_target_e, 32'h108);
        chk("reload.pc_plus4", pc_plus4_e, 32'h44);

`ifdef FORWARDING_EN
        v = mk(4'b0000, 3'b000, 0, 0, 0, 0, 0, 32'h1, 32'h3, 32'h0, 32'h0, 32'hA, 32'h3, 32'h0, 0);
        drive(v);
        @(posedge clk); #1;
        forward_a_e = 2'b10; alu_result_m = 32'h7;
        #1 check_vec("fwd_m", v);
        forward_a_e = 2'b00; forward_b_e = 2'b01; result_w = 32'h20;
        #1 chk("fwd_w.wdata", write_data_e, 32'h20);
        forward_b_e = 2'b00;
`endif

        // Randomized stimulus against the reference model
        for (int i = 0; i < 300; i++) begin
            v.alu = 4'($urandom_range(0, 15)); v.f3 = 3'($urandom);
            v.branch = 1'($urandom); v.jump = 1'($urandom_range(0, 3) == 0);
            v.src_a = 1'($urandom); v.src_b = 1'($urandom); v.adder = 1'($urandom);
            v.rd1 = $urandom; v.rd2 = ($urandom_range(0, 3) == 0) ? v.rd1 : $urandom;
            v.pc = $urandom & 32'hFFFF_FFFC; v.imm = $urandom;
            rd_exp = 5'($urandom); pcp4_exp = v.pc + 4;
            rd_d = rd_exp; pc_plus4_d = pcp4_exp;
            reg_write_d = 1'($urandom); mem_write_d = 1'($urandom);
            a_val = v.src_a ? v.pc : v.rd1;
            b_val = v.src_b ? v.imm : v.rd2;
            tgt   = v.adder ? ((v.rd1 + v.imm) & ~32'h1) : (v.pc + v.imm);
            v.exp_alu = model_alu(v.alu, a_val, b_val);
            v.exp_wd  = v.rd2;
            v.exp_tgt = tgt;
            v.exp_src = v.jump | (v.branch & model_taken(v.f3, v.rd1, v.rd2));
            drive(v);
            @(posedge clk); #1;
            check_vec($sformatf("rnd%0d", i), v);
            chk($sformatf("rnd%0d.rd", i), 32'(rd_e), 32'(rd_exp));
            chk($sformatf("rnd%0d.pc_plus4", i), pc_plus4_e, pcp4_exp);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
